// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with zero/replicate borders; output registered one cycle after each step.
// Back-pressure: a stalled output freezes all state and deasserts s_ready; the last row drains via FLUSH.
module conv3x3_stream #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int INPUT_WIDTH     = 8,
    parameter int IMAGE_WIDTH     = 512,
    parameter int IMAGE_HEIGHT    = 512,
    parameter int COEF_WIDTH      = 5,
    parameter int DATA_WIDTH      = INPUT_WIDTH * PIXELS_PER_BEAT
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic [9*COEF_WIDTH-1:0] cfg_coef,
    input  logic [3:0]              cfg_shift,
    input  logic                    cfg_border,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_sof,
    output logic                    m_last
);
    localparam int PPB   = PIXELS_PER_BEAT;
    localparam int IW    = INPUT_WIDTH;
    localparam int CW    = COEF_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int SW    = IW + CW + 4;
    localparam int BEATS = IMAGE_WIDTH / PPB;
    localparam int CB    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RB    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [CB-1:0] LAST_COL = CB'(BEATS - 1);
    localparam logic [RB-1:0] LAST_ROW = RB'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [CB-1:0]       col_q, col_d, ld_col, out_col;
    logic [RB-1:0]       row_q, row_d;
    logic                sel_q, sel_d;
    logic [9*CW-1:0]     coef_q, coef_d;
    logic [3:0]          shift_q, shift_d;
    logic                border_q, border_d;
    logic [2:0][DW-1:0]  win_q, win_d, new_col;
    logic [2:0][IW-1:0]  prev_q, prev_d;
    logic                m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_last_q, m_last_d;
    logic [DW-1:0]       m_data_q, m_data_d;

    logic                adv, in_rdy, accept, step, emit, cfg_ld;
    logic [DW-1:0]       mid_rd, top_rd, pad_col, out_dat;
    logic [IW-1:0]       ext [3][PPB+2];
    logic signed [SW-1:0] acc, res;
    logic [IW-1:0]       pix;

    // Two rows in a ring: sel_q points at row r-1, the other bank holds r-2 and takes row r.
    logic [DW-1:0] line_mem [2][BEATS];

    always_ff @(posedge clk) begin
        if (accept) line_mem[~sel_q][col_q] <= s_data;
    end

    always_comb begin
        adv    = ~m_valid_q | m_ready;
        in_rdy = adv & ((state_q == FILL) | (state_q == RUN));
        accept = s_valid & in_rdy;
        step   = accept | (adv & ((state_q == DRAIN) | (state_q == FLUSH)));
        emit   = step & (((state_q == RUN) & (col_q != '0)) | (state_q == DRAIN) | (state_q == FLUSH));
        cfg_ld = accept & (state_q == FILL) & (col_q == '0);
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        sel_d   = sel_q;
        if (step) begin
            unique case (state_q)
                FILL, RUN: begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        sel_d   = ~sel_q;
                        state_d = (state_q == FILL) ? RUN : DRAIN;
                        if (state_q == FILL) row_d = RB'(1);
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (row_q == LAST_ROW) begin
                        state_d = FLUSH;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        row_d   = '0;
                        state_d = FILL;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Column entering the window; the last-row DRAIN preloads column 0 of the bottom-border row.
    always_comb begin
        ld_col = col_q;
        if (state_q == DRAIN) ld_col = '0;
        else if ((state_q == FLUSH) && (col_q != LAST_COL)) ld_col = col_q + 1'b1;
        mid_rd     = line_mem[sel_q][ld_col];
        top_rd     = line_mem[~sel_q][ld_col];
        pad_col    = border_q ? mid_rd : '0;
        new_col[0] = ((state_q == RUN) && (row_q == RB'(1))) ? pad_col : top_rd;
        new_col[1] = mid_rd;
        new_col[2] = (state_q == RUN) ? s_data : pad_col;
        out_col    = col_q - 1'b1;
        if (state_q == DRAIN) out_col = LAST_COL;
        else if (state_q == FLUSH) out_col = col_q;
    end

    always_comb begin
        ext = '{default: '0};
        for (int r = 0; r < 3; r++) begin
            for (int l = 0; l < PPB; l++) ext[r][l+1] = win_q[r][DW-1-l*IW -: IW];
            ext[r][0]     = (out_col == '0) ? (border_q ? win_q[r][DW-1 -: IW] : '0) : prev_q[r];
            ext[r][PPB+1] = (out_col == LAST_COL) ? (border_q ? win_q[r][IW-1:0] : '0)
                                                  : new_col[r][DW-1 -: IW];
        end
    end

    always_comb begin
        out_dat = '0;
        acc     = '0;
        res     = '0;
        pix     = '0;
        for (int l = 0; l < PPB; l++) begin
            acc = '0;
            for (int t = 0; t < 9; t++) begin
                acc = acc + $signed({{(SW-IW){1'b0}}, ext[t/3][l + t%3]})
                          * $signed({{(SW-CW){coef_q[t*CW+CW-1]}}, coef_q[t*CW +: CW]});
            end
            res = acc >>> shift_q;
            if (res[SW-1])            pix = '0;
            else if (|res[SW-2:IW])   pix = '1;
            else                      pix = res[IW-1:0];
            out_dat[DW-1-l*IW -: IW] = pix;
        end
    end

    always_comb begin
        coef_d    = cfg_ld ? cfg_coef   : coef_q;
        shift_d   = cfg_ld ? cfg_shift  : shift_q;
        border_d  = cfg_ld ? cfg_border : border_q;
        win_d     = win_q;
        prev_d    = prev_q;
        if (step) begin
            for (int r = 0; r < 3; r++) prev_d[r] = win_q[r][IW-1:0];
            win_d = new_col;
        end
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sof_d   = m_sof_q;
        m_last_d  = m_last_q;
        if (adv) begin
            m_valid_d = emit;
            if (emit) begin
                m_data_d = out_dat;
                m_sof_d  = (state_q == RUN) && (row_q == RB'(1)) && (col_q == CB'(1));
                m_last_d = (state_q == FLUSH) && (col_q == LAST_COL);
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= FILL;
            col_q     <= '0;
            row_q     <= '0;
            sel_q     <= 1'b0;
            coef_q    <= '0;
            shift_q   <= '0;
            border_q  <= 1'b0;
            win_q     <= '0;
            prev_q    <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            sel_q     <= sel_d;
            coef_q    <= coef_d;
            shift_q   <= shift_d;
            border_q  <= border_d;
            win_q     <= win_d;
            prev_q    <= prev_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sof_q   <= m_sof_d;
            m_last_q  <= m_last_d;
        end
    end

    assign s_ready = in_rdy & ~areset;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sof   = m_sof_q;
    assign m_last  = m_last_q;
endmodule
